// File: rtl/pwm_fade_if.sv
// pwm_fade_if: config handshake carrying target, step and prescaler into the fade controller
interface pwm_fade_if #(
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DUTY_W-1:0]  cfg_target;
  logic [DUTY_W-1:0]  cfg_step;
  logic [PRESC_W-1:0] cfg_presc;
  modport master (output cfg_valid, cfg_target, cfg_step, cfg_presc, input cfg_ready);
  modport slave  (input cfg_valid, cfg_target, cfg_step, cfg_presc, output cfg_ready);
endinterface

// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller: ramps duty_o to a commanded target in clamped steps at a prescaled tick rate
// FADE_BREATHE_EN makes the ramp ping-pong endlessly between the accept-time duty and the target
module pwm_fade_controller #(
  parameter int DUTY_W    = 8,
  parameter int PRESC_W   = 16,
  parameter int INIT_DUTY = 0
) (
  input  logic              clk,
  input  logic              rst,
  pwm_fade_if.slave         cfg,
  input  logic              abort_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              busy_o,
  output logic              done_o
);
  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
  localparam logic [DUTY_W-1:0] INIT = DUTY_W'(INIT_DUTY);
  state_t             state_q, state_d;
  logic [DUTY_W-1:0]  duty_q, duty_d, target_q, target_d, step_q, step_d, nxt;
  logic [PRESC_W-1:0] presc_q, presc_d, cnt_q, cnt_d;
  logic               up_q, up_d, busy_q, busy_d, done_q, done_d;
  logic               accept, same, tick, land;
  logic [DUTY_W:0]    sum, diff;
`ifdef FADE_BREATHE_EN
  logic [DUTY_W-1:0]  origin_q, origin_d;
  assign cfg.cfg_ready = !abort_i;
`else
  assign cfg.cfg_ready = (state_q != RAMP) && !abort_i;
`endif
  assign accept = cfg.cfg_valid && cfg.cfg_ready;
  assign same   = cfg.cfg_target == duty_q;
  assign tick   = (state_q == RAMP) && (cnt_q == presc_q);
  // one extra bit so the clamp sees carry/borrow instead of a wrapped value
  assign sum    = {1'b0, duty_q} + {1'b0, step_q};
  assign diff   = {1'b0, duty_q} - {1'b0, step_q};
  assign nxt    = up_q ? ((sum >= {1'b0, target_q}) ? target_q : sum[DUTY_W-1:0])
                       : ((diff[DUTY_W] || diff[DUTY_W-1:0] <= target_q) ? target_q : diff[DUTY_W-1:0]);
  assign land   = tick && !abort_i && (nxt == target_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= INIT;
      target_q <= '0;
      step_q   <= '0;
      presc_q  <= '0;
      cnt_q    <= '0;
      up_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FADE_BREATHE_EN
      origin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FADE_BREATHE_EN
      origin_q <= origin_d;
`endif
    end
  end
  always_comb begin
`ifdef FADE_BREATHE_EN
    state_d = abort_i ? IDLE : accept ? (same ? HOLD : RAMP) : state_q;
`else
    state_d = abort_i ? IDLE : accept ? (same ? HOLD : RAMP) : land ? HOLD : state_q;
`endif
  end
  always_comb begin
    duty_d   = (tick && !abort_i && !accept) ? nxt : duty_q;
    cnt_d    = tick ? '0 : (state_q == RAMP) ? cnt_q + 1'b1 : cnt_q;
    target_d = target_q;
    step_d   = step_q;
    presc_d  = presc_q;
    up_d     = up_q;
`ifdef FADE_BREATHE_EN
    origin_d = origin_q;
`endif
    if (accept) begin
      target_d = cfg.cfg_target;
      step_d   = (cfg.cfg_step == '0) ? DUTY_W'(1) : cfg.cfg_step;
      presc_d  = cfg.cfg_presc;
      up_d     = cfg.cfg_target > duty_q;
      cnt_d    = '0;
`ifdef FADE_BREATHE_EN
      origin_d = duty_q;
    end else if (land) begin
      target_d = origin_q;
      origin_d = target_q;
      up_d     = !up_q;
`endif
    end
  end
  always_comb begin
    busy_d = state_d == RAMP;
    done_d = !abort_i && ((accept && same) || (land && !accept));
  end
  assign duty_o = duty_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_pwm_fade_controller.sv
// tb_pwm_fade_controller: directed checks of ramp timing, clamping, abort, reset and breathing
module tb_pwm_fade_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic [7:0] duty;
  logic       busy, done;
  int         checks = 0;
  int         errors = 0;
  int         down_seq[4] = '{140, 80, 20, 5};
  int         breathe_seq[5] = '{25, 40, 25, 10, 25};
  pwm_fade_if #(.DUTY_W(8), .PRESC_W(16)) bus();
  pwm_fade_controller #(.DUTY_W(8), .PRESC_W(16), .INIT_DUTY(0)) dut (
    .clk(clk), .rst(rst), .cfg(bus.slave), .abort_i(abort),
    .duty_o(duty), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input int d, input int b, input int dn);
    chk({tag, ".duty"}, 32'(duty), d);
    chk({tag, ".busy"}, 32'(busy), b);
    chk({tag, ".done"}, 32'(done), dn);
  endtask
  task automatic send(input int t, input int s, input int p);
    bus.cfg_valid  = 1'b1;
    bus.cfg_target = 8'(t);
    bus.cfg_step   = 8'(s);
    bus.cfg_presc  = 16'(p);
    tick();
    bus.cfg_valid  = 1'b0;
  endtask
  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_target = '0;
    bus.cfg_step   = '0;
    bus.cfg_presc  = '0;
    repeat (2) tick();
    chk_out("reset", 0, 0, 0);
    chk("reset.ready", 32'(bus.cfg_ready), 1);
    rst = 1'b0;
`ifdef FADE_BREATHE_EN
    send(10, 10, 0);
    chk_out("br_start", 0, 1, 0);
    tick();
    chk_out("br_first", 10, 1, 1);
    abort = 1'b1;
    tick();
    chk_out("br_abort", 10, 0, 0);
    abort = 1'b0;
    send(40, 15, 0);
    chk_out("br_accept", 10, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("br_loop", breathe_seq[k], 1, int'(breathe_seq[k] == 40 || breathe_seq[k] == 10));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("br_exit", 25, 0, 0);
`else
    bus.cfg_valid  = 1'b1;
    bus.cfg_target = 8'd100;
    bus.cfg_step   = 8'd25;
    bus.cfg_presc  = 16'd3;
    #1;
    chk("up.ready_idle", 32'(bus.cfg_ready), 1);
    tick();
    bus.cfg_valid = 1'b0;
    chk_out("up.accept", 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) tick();
      chk("up.wait", 32'(duty), 25 * (k - 1));
      chk("up.ready_ramp", 32'(bus.cfg_ready), 0);
      tick();
      chk_out("up.step", 25 * k, int'(k != 4), int'(k == 4));
    end
    tick();
    chk_out("up.hold", 100, 0, 0);
    send(100, 5, 0);
    chk_out("same.done", 100, 0, 1);
    tick();
    chk_out("same.after", 100, 0, 0);
    send(103, 0, 0);
    chk_out("step0.accept", 100, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_out("step0.step", 100 + k, int'(k != 3), int'(k == 3));
    end
    send(200, 255, 0);
    tick();
    chk_out("big_up", 200, 0, 1);
    send(5, 60, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("down", down_seq[k], int'(k != 3), int'(k == 3));
    end
    send(255, 200, 0);
    tick();
    chk_out("clamp.mid", 205, 1, 0);
    tick();
    chk_out("clamp.top", 255, 0, 1);
    send(0, 255, 0);
    tick();
    chk_out("clamp.bottom", 0, 0, 1);
    send(100, 25, 1);
    repeat (4) tick();
    chk_out("abort.pre", 50, 1, 0);
    abort          = 1'b1;
    bus.cfg_valid  = 1'b1;
    bus.cfg_target = 8'd7;
    #1;
    chk("abort.ready", 32'(bus.cfg_ready), 0);
    tick();
    chk_out("abort.idle", 50, 0, 0);
    abort         = 1'b0;
    bus.cfg_valid = 1'b0;
    #1;
    chk("abort.ready_after", 32'(bus.cfg_ready), 1);
    repeat (3) tick();
    chk_out("abort.frozen", 50, 0, 0);
    send(200, 10, 0);
    repeat (2) tick();
    chk_out("rst.pre", 70, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk_out("rst.async", 0, 0, 0);
    #2 rst = 1'b0;
    tick();
    chk_out("rst.after", 0, 0, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
